iir_sample_sink: RTL

Synthesizable receive-side endpoint for the IIR filter's sample stream: consumes the `data_out`/`valid_out` strobe stream leaving the filter top. It buffers accepted samples in a circular RAM for later read-out, checks that strobes arrive at the fixed sample cadence, and reports occupancy, overflow and cadence errors. It sits directly downstream of the filter top, at the opposite end of the strobe-paced 24-bit sample interface that drives the filter input.

---
 rtl/iir_sink_pkg.sv | 11 +
 rtl/iir_sink_ram.sv | 32 +++
 rtl/iir_sample_sink.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/iir_sink_pkg.sv
// Shared defaults for the IIR sample sink: widths, cadence and counter limits.
package iir_sink_pkg;

  localparam int DW_DEF    = 24;
  localparam int SAMP_DEF  = 10;
  localparam int DEPTH_DEF = 2048;
  localparam int GAP_MAX   = 255;
  localparam int GAP_W     = 8;
  localparam int ERR_CNT_W = 16;

endpackage

// File: rtl/iir_sink_ram.sv
// Simple dual-port sample buffer: one write port, registered read port (block-RAM style).
module iir_sink_ram #(
  parameter  int DW    = 24,
  parameter  int DEPTH = 2048,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Output register holds its value between pops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/iir_sample_sink.sv
// Receive endpoint for the IIR output stream: circular buffer, cadence checker, peak tracker.
// Define IIR_SINK_PEAK_EN to build the |sample| peak tracker; otherwise peak is tied to 0.
module iir_sample_sink
  import iir_sink_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int SAMP  = SAMP_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic [DW-1:0]            data_in,
  input  logic                     valid_in,
  input  logic                     rd_en,
  output logic [DW-1:0]            rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow,
  output logic                     interval_err,
  output logic [ERR_CNT_W-1:0]     err_cnt,
  output logic [DW-1:0]            peak
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic                 interval_err_q, interval_err_d;
  logic                 first_seen_q, first_seen_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 wr_acc, rd_acc, off_cadence;

  // full/empty come from pre-edge count, so a same-cycle pop never rescues a write.
  assign empty       = (count_q == '0);
  assign full        = (count_q == CW'(DEPTH));
  assign wr_acc      = valid_in && !full && !clr;
  assign rd_acc      = rd_en && !empty && !clr;
  assign off_cadence = valid_in && first_seen_q && (gap_q != GAP_W'(SAMP));

  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    overflow_d     = overflow_q;
    interval_err_d = interval_err_q;
    first_seen_d   = first_seen_q;
    gap_d          = gap_q;
    err_cnt_d      = err_cnt_q;
    rd_valid_d     = rd_acc;
    if (clr) begin
      wr_ptr_d       = '0;
      rd_ptr_d       = '0;
      count_d        = '0;
      overflow_d     = 1'b0;
      interval_err_d = 1'b0;
      first_seen_d   = 1'b0;
      gap_d          = '0;
      err_cnt_d      = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (valid_in && full) overflow_d = 1'b1;
      if (valid_in) begin
        first_seen_d = 1'b1;
        gap_d        = GAP_W'(1);
      end else if (gap_q != GAP_W'(GAP_MAX)) begin
        gap_d = gap_q + 1'b1;
      end
      if (off_cadence) begin
        interval_err_d = 1'b1;
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      overflow_q     <= 1'b0;
      interval_err_q <= 1'b0;
      first_seen_q   <= 1'b0;
      gap_q          <= '0;
      err_cnt_q      <= '0;
      rd_valid_q     <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      overflow_q     <= overflow_d;
      interval_err_q <= interval_err_d;
      first_seen_q   <= first_seen_d;
      gap_q          <= gap_d;
      err_cnt_q      <= err_cnt_d;
      rd_valid_q     <= rd_valid_d;
    end
  end

  iir_sink_ram #(.DW(DW), .DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_in),
    .re_i    (rd_acc),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

`ifdef IIR_SINK_PEAK_EN
  logic [DW-1:0] peak_q, peak_d, mag;

  // Two's-complement negate of the most negative value yields 2^(DW-1), which fits unsigned.
  assign mag = data_in[DW-1] ? (~data_in + 1'b1) : data_in;

  always_comb begin
    peak_d = peak_q;
    if (clr)                        peak_d = '0;
    else if (wr_acc && mag > peak_q) peak_d = mag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) peak_q <= '0;
    else        peak_q <= peak_d;
  end

  assign peak = peak_q;
`else
  assign peak = '0;
`endif

  assign count        = count_q;
  assign overflow     = overflow_q;
  assign interval_err = interval_err_q;
  assign err_cnt      = err_cnt_q;
  assign rd_valid     = rd_valid_q;

endmodule
